// File: rtl/freelist_pkg.sv
// Shared types for the physical-register free-list controller.
package freelist_pkg;
   typedef enum logic {INIT = 1'b0, READY = 1'b1} fl_state_t;

   localparam int FL_INDEX = 5;
   typedef logic [FL_INDEX:0] fl_ptr_t;
endpackage

// File: rtl/freelist_compact.sv
// Prefix-sum of the per-slot free requests: write-port offset per slot plus total count.
module freelist_compact
   import freelist_pkg::*;
#(
   parameter int COMMIT_WIDTH = 4,
   parameter int CNT_W        = $clog2(COMMIT_WIDTH + 1)
) (
   input  logic [COMMIT_WIDTH-1:0]       valid,
   output logic [COMMIT_WIDTH*CNT_W-1:0] offset,
   output logic [CNT_W-1:0]              count
);
   always_comb begin
      logic [CNT_W-1:0] run;
      run    = '0;
      offset = '0;
      for (int s = 0; s < COMMIT_WIDTH; s++) begin
         offset[s*CNT_W +: CNT_W] = run;
         run = run + CNT_W'(valid[s]);
      end
      count = run;
   end
endmodule

// File: rtl/freelist_ctrl.sv
// Free-list controller: self-initialises the tag RAM, allocates tag bundles,
// compacts retired tags into the tail and rewinds speculative allocations on flush.
module freelist_ctrl
   import freelist_pkg::*;
#(
   parameter int DISPATCH_WIDTH = 4,
   parameter int COMMIT_WIDTH   = 4,
   parameter int DEPTH          = 32,
   parameter int INDEX          = 5,
   parameter int WIDTH          = 7,
   parameter int BASE           = 32
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   alloc_valid_i,
   output logic                                   alloc_ready_o,
   output logic [DISPATCH_WIDTH*WIDTH-1:0]        alloc_tag_o,
   input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]    commit_alloc_cnt_i,
   input  logic [COMMIT_WIDTH-1:0]                free_valid_i,
   input  logic [COMMIT_WIDTH*WIDTH-1:0]          free_tag_i,
   input  logic                                   flush_i,
   output logic [DISPATCH_WIDTH*INDEX-1:0]        rd_addr_o,
   input  logic [DISPATCH_WIDTH*WIDTH-1:0]        rd_data_i,
   output logic [COMMIT_WIDTH-1:0]                wr_en_o,
   output logic [COMMIT_WIDTH*INDEX-1:0]          wr_addr_o,
   output logic [COMMIT_WIDTH*WIDTH-1:0]          wr_data_o,
   output logic [INDEX:0]                         free_cnt_o,
   output logic                                   overflow_o
);
   localparam int OW = $clog2(COMMIT_WIDTH + 1);

   fl_state_t                  state, state_next;
   logic [INDEX:0]             head, tail, chead, init_idx;
   logic [INDEX:0]             chead_next, free_cnt;
   logic [COMMIT_WIDTH*OW-1:0] offset;
   logic [OW-1:0]              pop;
   logic                       grant, over, overflow;

   freelist_compact #(.COMMIT_WIDTH(COMMIT_WIDTH), .CNT_W(OW)) u_compact (
      .valid  (free_valid_i),
      .offset (offset),
      .count  (pop)
   );

   // Pointers carry a wrap bit, so the modular difference is the occupancy.
   assign free_cnt      = tail - head;
   assign free_cnt_o    = free_cnt;
   assign overflow_o    = overflow;
   assign alloc_tag_o   = rd_data_i;
   assign alloc_ready_o = (state == READY) && (free_cnt >= (INDEX+1)'(DISPATCH_WIDTH));
   assign grant         = alloc_valid_i && alloc_ready_o && !flush_i;
   assign over          = ({1'b0, free_cnt} + (INDEX+2)'(pop)) > (INDEX+2)'(DEPTH);
   assign chead_next    = (state == READY) ? chead + (INDEX+1)'(commit_alloc_cnt_i) : chead;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= INIT;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         INIT:    if (({1'b0, init_idx} + (INDEX+2)'(COMMIT_WIDTH)) >= (INDEX+2)'(DEPTH))
                     state_next = READY;
         default: state_next = READY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head     <= '0;
         tail     <= '0;
         chead    <= '0;
         init_idx <= '0;
         overflow <= 1'b0;
      end else if (state == INIT) begin
         init_idx <= init_idx + (INDEX+1)'(COMMIT_WIDTH);
         if (state_next == READY) tail <= (INDEX+1)'(DEPTH);
      end else begin
         chead <= chead_next;
         if (flush_i)    head <= chead_next;
         else if (grant) head <= head + (INDEX+1)'(DISPATCH_WIDTH);
         if (over)       overflow <= 1'b1;
         else            tail     <= tail + (INDEX+1)'(pop);
      end
   end

   always_comb begin
      rd_addr_o = '0;
      for (int k = 0; k < DISPATCH_WIDTH; k++)
         rd_addr_o[k*INDEX +: INDEX] = INDEX'(int'(head) + k);
   end

   // Write ports: init fill, or the j-th valid free slot routed to port j.
   always_comb begin
      wr_en_o   = '0;
      wr_addr_o = '0;
      wr_data_o = '0;
      if (state == INIT) begin
         for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (!reset && (int'(init_idx) + k < DEPTH)) begin
               wr_en_o[k]                  = 1'b1;
               wr_addr_o[k*INDEX +: INDEX] = INDEX'(int'(init_idx) + k);
               wr_data_o[k*WIDTH +: WIDTH] = WIDTH'(BASE + int'(init_idx) + k);
            end
         end
      end else if (!over) begin
         for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (int'(pop) > k) begin
               wr_en_o[k]                  = 1'b1;
               wr_addr_o[k*INDEX +: INDEX] = INDEX'(int'(tail) + k);
               for (int s = 0; s < COMMIT_WIDTH; s++)
                  if (free_valid_i[s] && (offset[s*OW +: OW] == OW'(k)))
                     wr_data_o[k*WIDTH +: WIDTH] = free_tag_i[s*WIDTH +: WIDTH];
            end
         end
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!reset && state == READY)
         assert ((INDEX+1)'(commit_alloc_cnt_i) <= (head - chead))
            else $error("freelist_ctrl: committed head passes head");
   end
`endif
endmodule

// File: tb/tb_freelist_ctrl.sv
// Directed bench for freelist_ctrl with a behavioural tag RAM as the parent.
module tb_freelist_ctrl;
   logic        clk, reset;
   logic        alloc_valid_i, alloc_ready_o, flush_i, overflow_o;
   logic [27:0] alloc_tag_o, rd_data_i, free_tag_i, wr_data_o;
   logic [2:0]  commit_alloc_cnt_i;
   logic [3:0]  free_valid_i, wr_en_o;
   logic [19:0] rd_addr_o, wr_addr_o;
   logic [5:0]  free_cnt_o;
   logic [6:0]  mem [32];
   int          tests = 0, fails = 0;

   freelist_ctrl dut (
      .clk(clk), .reset(reset), .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
      .alloc_tag_o(alloc_tag_o), .commit_alloc_cnt_i(commit_alloc_cnt_i),
      .free_valid_i(free_valid_i), .free_tag_i(free_tag_i), .flush_i(flush_i),
      .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .wr_en_o(wr_en_o),
      .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .free_cnt_o(free_cnt_o),
      .overflow_o(overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      for (int k = 0; k < 4; k++)
         if (wr_en_o[k]) mem[wr_addr_o[k*5 +: 5]] <= wr_data_o[k*7 +: 7];

   always_comb begin
      rd_data_i = '0;
      for (int k = 0; k < 4; k++) rd_data_i[k*7 +: 7] = mem[rd_addr_o[k*5 +: 5]];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
         else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
         end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [19:0] ea;
      logic [27:0] ed;
      reset = 1'b1; alloc_valid_i = 0; commit_alloc_cnt_i = 0;
      free_valid_i = 0; free_tag_i = 0; flush_i = 0;
      #12;
      check("rst_free_cnt", free_cnt_o, 0);
      check("rst_ready", alloc_ready_o, 0);
      check("rst_wr_en", wr_en_o, 0);
      check("rst_overflow", overflow_o, 0);
      step();
      reset = 1'b0;
      #1;

      // 1. init fill
      check("init_ready0", alloc_ready_o, 0);
      for (int c = 0; c < 8; c++) begin
         for (int k = 0; k < 4; k++) begin
            ea[k*5 +: 5] = 5'(4*c + k);
            ed[k*7 +: 7] = 7'(32 + 4*c + k);
         end
         check("init_wr_en", wr_en_o, 4'hF);
         check("init_wr_addr", wr_addr_o, ea);
         check("init_wr_data", wr_data_o, ed);
         step();
      end
      check("init_free_cnt", free_cnt_o, 32);
      check("init_ready", alloc_ready_o, 1);
      check("init_mem0", mem[0], 32);
      check("init_mem31", mem[31], 63);

      // 2. two grants
      alloc_valid_i = 1;
      check("alloc_tag0", alloc_tag_o, {7'd35, 7'd34, 7'd33, 7'd32});
      step();
      check("alloc_tag1", alloc_tag_o, {7'd39, 7'd38, 7'd37, 7'd36});
      step();
      alloc_valid_i = 0;
      #1;
      check("alloc_free_cnt", free_cnt_o, 24);

      // 3. free compaction
      free_valid_i = 4'b1010;
      free_tag_i   = {7'd41, 7'd0, 7'd40, 7'd0};
      #1;
      check("cmp_wr_en", wr_en_o, 4'b0011);
      check("cmp_wr_addr", wr_addr_o, {5'd0, 5'd0, 5'd1, 5'd0});
      check("cmp_wr_data", wr_data_o, {7'd0, 7'd0, 7'd41, 7'd40});
      check("cmp_cnt_same", free_cnt_o, 24);
      step();
      free_valid_i = 0;
      #1;
      check("cmp_cnt_next", free_cnt_o, 26);

      // 4. starvation
      free_valid_i = 4'b0001;
      free_tag_i   = {7'd0, 7'd0, 7'd0, 7'd42};
      step();
      free_valid_i = 0;
      #1;
      check("stv_cnt27", free_cnt_o, 27);
      alloc_valid_i = 1;
      for (int i = 0; i < 6; i++) begin
         check("stv_ready", alloc_ready_o, 1);
         step();
      end
      check("stv_cnt3", free_cnt_o, 3);
      check("stv_not_ready", alloc_ready_o, 0);
      step();
      check("stv_cnt_hold", free_cnt_o, 3);
      free_valid_i = 4'b0001;
      free_tag_i   = {7'd0, 7'd0, 7'd0, 7'd43};
      #1;
      check("stv_ready_same", alloc_ready_o, 0);
      step();
      free_valid_i = 0;
      #1;
      check("stv_ready_next", alloc_ready_o, 1);
      check("stv_cnt4", free_cnt_o, 4);
      alloc_valid_i = 0;
      check("stv_wrap_tag", alloc_tag_o, {7'd43, 7'd42, 7'd41, 7'd40});

      // mid-run reset restarts init
      reset = 1'b1;
      #1;
      check("mrst_free_cnt", free_cnt_o, 0);
      check("mrst_ready", alloc_ready_o, 0);
      check("mrst_wr_en", wr_en_o, 0);
      step();
      reset = 1'b0;
      #1;
      check("mrst_init_en", wr_en_o, 4'hF);
      check("mrst_init_addr", wr_addr_o, {5'd3, 5'd2, 5'd1, 5'd0});
      for (int c = 0; c < 8; c++) step();
      check("mrst_full", free_cnt_o, 32);

      // 5. flush rewinds to committed head
      alloc_valid_i = 1;
      step();
      commit_alloc_cnt_i = 3'd4;
      step();
      commit_alloc_cnt_i = 3'd0;
      step();
      flush_i = 1;
      #1;
      check("fl_ready", alloc_ready_o, 1);
      check("fl_cnt_before", free_cnt_o, 20);
      step();
      flush_i = 0;
      alloc_valid_i = 0;
      #1;
      check("fl_free_cnt", free_cnt_o, 28);
      check("fl_head_tag", alloc_tag_o, {7'd39, 7'd38, 7'd37, 7'd36});

      // 6. overflow
      free_valid_i = 4'b0111;
      free_tag_i   = {7'd0, 7'd52, 7'd51, 7'd50};
      step();
      free_valid_i = 0;
      #1;
      check("ov_cnt31", free_cnt_o, 31);
      check("ov_flag0", overflow_o, 0);
      free_valid_i = 4'b1001;
      free_tag_i   = {7'd54, 7'd0, 7'd0, 7'd53};
      #1;
      check("ov_wr_en", wr_en_o, 0);
      step();
      free_valid_i = 0;
      #1;
      check("ov_cnt_hold", free_cnt_o, 31);
      check("ov_flag1", overflow_o, 1);
      step();
      check("ov_sticky", overflow_o, 1);
      free_valid_i = 4'b0100;
      free_tag_i   = {7'd0, 7'd55, 7'd0, 7'd0};
      #1;
      check("ov_post_en", wr_en_o, 4'b0001);
      check("ov_post_addr", wr_addr_o[4:0], 3);
      check("ov_post_data", wr_data_o[6:0], 55);
      step();
      free_valid_i = 0;
      #1;
      check("ov_post_cnt", free_cnt_o, 32);
      check("ov_post_flag", overflow_o, 1);
      reset = 1'b1;
      #1;
      check("ov_rst_clear", overflow_o, 0);
      step();
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/freelist_ctrl.md
# freelist_ctrl

Controller that owns the physical-register free list: it sequences the multi-ported free-list RAM, hands out physical tags to the rename/dispatch stage and returns retired tags from commit. It sits between rename (allocation), retire (freeing) and the pipeline flush logic. After reset it runs a self-initialisation sequence that fills the RAM with tags `BASE..BASE+DEPTH-1`. On a flush it rewinds speculative allocations to the committed head.

## Interface
- `DISPATCH_WIDTH`, default 4: tags allocated per granted bundle, which is also the number of RAM read ports.
- `COMMIT_WIDTH`, default 4: free slots per cycle, which is also the number of RAM write ports.
- `DEPTH`, default 32: number of free-list entries; must be a power of two.
- `INDEX`, default 5: log2(`DEPTH`).
- `WIDTH`, default 7: physical tag width.
- `BASE`, default 32: first tag written at init (equals `SIZE_RMT`).

Ports:
- `clk`  in  1  clock. One clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `alloc_valid_i`  in  1  rename requests one bundle of `DISPATCH_WIDTH` tags.
- `alloc_ready_o`  out  1  a full bundle can be granted this cycle.
- `alloc_tag_o`  out  `DISPATCH_WIDTH`×`WIDTH`  tags for the current bundle (equals `rd_data_i`).
- `commit_alloc_cnt_i`  in  clog2(`DISPATCH_WIDTH`+1)  allocations retired this cycle; advances the committed head.
- `free_valid_i`  in  `COMMIT_WIDTH`  per-slot free request; any bit pattern is allowed.
- `free_tag_i`  in  `COMMIT_WIDTH`×`WIDTH`  tags to return.
- `flush_i`  in  1  recover: rewind the head to the committed head.
- `rd_addr_o`  out  `DISPATCH_WIDTH`×`INDEX`  RAM read addresses.
- `rd_data_i`  in  `DISPATCH_WIDTH`×`WIDTH`  RAM asynchronous read data.
- `wr_en_o`, `wr_addr_o`, `wr_data_o`  out  `COMMIT_WIDTH`×(1/`INDEX`/`WIDTH`)  RAM write ports.
- `free_cnt_o`  out  `INDEX`+1  current number of free entries.
- `overflow_o`  out  1  sticky error flag: a free was attempted while the list was full.

## Operation
**Pointers.** `head`, `tail` and `chead` (committed head) are each `INDEX`+1 bits and include a wrap bit.
- RAM address = low `INDEX` bits of a pointer.
- `free_cnt_o = tail − head`, computed modulo 2^(`INDEX`+1).

**State machine.** States are `INIT` and `READY`.
- Reset enters `INIT` with `init_idx` = 0.
- In `INIT`, write port k writes address `init_idx+k` with data `BASE+init_idx+k`. `init_idx` then advances by `COMMIT_WIDTH`.
- When `init_idx` reaches `DEPTH`, the block moves to `READY` and sets `tail` = `DEPTH` (full). `head` and `chead` stay 0.
- In `INIT`, `alloc_ready_o` = 0, and `flush_i`, `free_valid_i` and `commit_alloc_cnt_i` are ignored.

**Allocate.**
- `rd_addr_o[k] = head + k`.
- `alloc_ready_o = READY && free_cnt_o ≥ DISPATCH_WIDTH`.
- A grant occurs when `alloc_valid_i && alloc_ready_o && !flush_i`. On a grant, `head += DISPATCH_WIDTH`.
- There is no partial grant.

**Free.**
- Valid slots are compacted in slot order to consecutive addresses starting at `tail`.
- The j-th valid slot writes `tail+j`.
- `tail += popcount(free_valid_i)`.
- Unused write ports are held with `wr_en_o` = 0.

**Commit.** `chead += commit_alloc_cnt_i` in `READY`. `chead` must never pass `head`; this is checked by assertion.

**Flush.** `head <= chead_next`, where `chead_next` includes this cycle's `commit_alloc_cnt_i`. Frees in the same cycle are still applied. The flush overrides any allocation in that cycle.

**Overflow.** If `free_cnt_o + popcount(free_valid_i) > DEPTH`:
- the writes are suppressed;
- `tail` is unchanged;
- `overflow_o` is set to 1 and stays set until reset.

## Timing
- Reset values: `head`/`tail`/`chead` = 0, `init_idx` = 0, `free_cnt_o` = 0, `alloc_ready_o` = 0, `wr_en_o` = 0, `overflow_o` = 0.
- Init takes `DEPTH/COMMIT_WIDTH` cycles; `alloc_ready_o` can first be 1 on the following cycle.
- `alloc_tag_o` is combinational from `head` in the same cycle. The pointer update takes effect at the next edge.
- A freed tag is written at the edge and counted in `free_cnt_o` from the next cycle. It is never allocatable in the cycle it is freed, because readiness uses the pre-update count.
- Wrap-around is handled implicitly by the pointer wrap bit: `tail` = `head` + `DEPTH` means full, `tail` = `head` means empty.
- A reset assertion mid-operation (init or run) immediately restores the reset values and restarts init.

## Structure
- Shared package `freelist_pkg` contains:
  - the `fl_state_t` enum (`INIT`, `READY`);
  - a pointer typedef of width `INDEX`+1.
- Sub-module `freelist_compact`: prefix-sum of `free_valid_i` producing per-slot offsets and the popcount. It is purely combinational.
- The RAM itself is instantiated outside this block, by the parent.

## Test plan
All scenarios use the default parameters.
1. **Init.** Deassert `reset` → 8 cycles of writes, addresses 0–31 with data 32–63 → then `free_cnt_o` = 32 and `alloc_ready_o` = 1.
2. **Allocate.** Two grants → `alloc_tag_o` = {32,33,34,35}, then {36,37,38,39}; `free_cnt_o` = 24.
3. **Free compaction.** `free_valid_i` = 4'b1010 with tags 40 and 41 → writes at addresses 0 and 1 with data 40 and 41; `free_cnt_o` rises by 2 the next cycle.
4. **Starvation.** Allocate down to `free_cnt_o` = 3 → `alloc_ready_o` = 0. Free 1 tag → `alloc_ready_o` = 1 the next cycle, not the same cycle.
5. **Flush.** Three grants, with `commit_alloc_cnt_i` = 4 once, then `flush_i` → `head` = 4 and `free_cnt_o` = 28. A concurrent `alloc_valid_i` is not granted.
6. **Overflow.** At `free_cnt_o` = 31, free 2 tags → no writes, `free_cnt_o` stays 31, and `overflow_o` = 1 and stays 1 until `reset`.
